fb_ctrl: RTL and testbench
==========================

# fb_ctrl

Single-port-write, single-port-read framebuffer controller that sits directly upstream of the VGA timing generator. It answers the generator's `req_addr` with pixel data one cycle later and accepts pixel writes from a drawing client through a valid/ready handshake. It also contains a hardware clear engine that fills the whole buffer with one colour. It runs in the video clock domain; `clk` is driven by the same clock as the generator's `vclk`.

## Interface
Parameters:
- `BUF_WIDTH`, 640, pixels per line.
- `BUF_HEIGHT`, 480, lines.
- `BIT_DEPTH`, 3, bits per pixel.

Ports:
- `clk`  in  1  video clock; all logic is on its rising edge.
- `srst`  in  1  synchronous, active-high reset.
- `rd_addr`  in  20  pixel address; connects to generator `req_addr`.
- `rd_pixel`  out  BIT_DEPTH  registered read data; connects to generator `pixel`.
- `visible`  in  1  generator `visible`.
- `frame_end`  in  1  generator `frame_end` (single-cycle pulse).
- `wr_valid`  in  1  client write request.
- `wr_ready`  out  1  write accepted this cycle when `wr_valid && wr_ready`.
- `wr_addr`  in  20  write address.
- `wr_pixel`  in  BIT_DEPTH  write data.
- `clear_req`  in  1  start a fill; sampled only in IDLE.
- `clear_color`  in  BIT_DEPTH  fill colour; latched on the accepted `clear_req`.
- `clear_busy`  out  1  high in every state except IDLE.
- `fill_done`  out  1  one-cycle pulse when a fill completes.

## Operation
- Storage: DEPTH = BUF_WIDTH*BUF_HEIGHT words of BIT_DEPTH bits, with one read port and one write port. Storage is not initialised by reset.
- Read path: `rd_pixel` <= mem[`rd_addr`] on every cycle, including during a fill. Reads never stall. If `rd_addr` >= DEPTH, `rd_pixel` <= 0.
- Write arbitration: the clear engine owns the write port whenever `clear_busy` is high. In that case `wr_ready` = 0.
- In IDLE, `wr_ready` = 1, qualified by the tear guard when it is compiled in.
- An accepted write with `wr_addr` >= DEPTH is dropped silently; the handshake still completes.
- Clear FSM states:
  - IDLE: on `clear_req`, latch `clear_color`, zero the fill counter, go to WAIT when the guard is compiled in, otherwise go to FILL.
  - WAIT: on `frame_end`, go to FILL.
  - FILL: write the latched colour to mem[counter] and increment the counter. One word is written per enabled cycle. After writing DEPTH-1, go to DONE.
  - DONE: `fill_done` = 1 for this cycle only, then go to IDLE.
- `clear_req` outside IDLE is ignored; it is not queued.
- Simultaneous `clear_req` and `wr_valid` in IDLE: the client write is accepted in that cycle. The FSM leaves IDLE on the next edge.
- Counter width is 20 bits. The terminal value is compared against the constant DEPTH-1, so the counter never wraps.

## Timing
- Read latency is exactly 1 cycle: the address presented at edge N appears on `rd_pixel` after edge N.
- A write accepted at edge N is visible to a read of the same address issued at edge N+1.
- A read of the same address at edge N returns the old data (read-before-write).
- Fill duration without the guard: DEPTH cycles in FILL, plus 1 cycle in DONE.
- Reset values: `rd_pixel` = 0, `clear_busy` = 0, `fill_done` = 0, state = IDLE, counter = 0, latched colour = 0.
- After reset, `wr_ready` = 1 without the guard, or `!visible` with it.
- `srst` during WAIT or FILL aborts the fill in the same edge, and `fill_done` is not pulsed. Already-written words keep the fill colour.

## Configuration
- Macro: `FB_TEAR_GUARD_EN`.
- Defined:
  - `wr_ready` = IDLE && !`visible`.
  - A fill first waits in WAIT for `frame_end`.
  - In FILL, writes and counter increments occur only on cycles with `visible` = 0; the state machine holds otherwise.
- Undefined:
  - WAIT is unreachable.
  - `wr_ready` = IDLE.
  - FILL writes every cycle regardless of `visible`.

## Structure
- Shared package `vga_pkg`:
  - the `fb_state_t` enum (IDLE, WAIT, FILL, DONE);
  - the `ADDR_W` = 20 constant;
  - a `pixel_t` typedef parameterised by the shared BIT_DEPTH default.
- Sub-module `fb_mem`: a simple dual-port RAM with a registered read port, and out-of-range masking in the top level. This keeps the RAM inferable by synthesis.

## Test plan
- Write/read: write 3'b101 to address 1000, then read address 1000 on the next cycle. `rd_pixel` = 3'b101 one cycle after the read address is presented.
- Read-before-write: write 3'b010 to address 5 and read address 5 in the same cycle (old value 3'b111). The first `rd_pixel` is 3'b111; reading again on the next cycle gives 3'b010.
- Fill, guard undefined, BUF_WIDTH=4, BUF_HEIGHT=2, `clear_color`=3'b011:
  - `clear_busy` high for exactly 9 cycles;
  - `fill_done` pulses once, in cycle 9;
  - all 8 addresses then read 3'b011;
  - `wr_ready` = 0 throughout the fill.
- Fill with guard:
  - hold `visible`=1 and pulse `frame_end`; the FSM moves to FILL and no writes occur while `visible`=1;
  - drop `visible`; the counter advances by 1 per cycle.
- Out-of-range: write to address DEPTH, then read address DEPTH. The write handshake completes, no stored word changes, and `rd_pixel` = 0.
- Reset mid-fill: assert `srst` in FILL with the counter at 3. Next cycle: `clear_busy` = 0, `fill_done` never pulses, addresses 0–2 read the fill colour, and address 3 and above are unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the video pipeline: framebuffer clear FSM
// state encoding, pixel address width, default pixel type and sizing helpers.
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned PIX_W  = 3;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } fb_state_t;

    // Number of words in a width x height buffer.
    function automatic int unsigned fb_depth(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    // RAM index width; never below one bit.
    function automatic int unsigned fb_addr_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fb_mem.sv
// ---------------------------------------------------------------------------
// fb_mem
// Simple dual-port RAM: one write port, one registered read port, both on clk.
// A same-address read and write on one edge returns the old word.
// Ports:
//   clk          clock
//   we/waddr/wdata  write port
//   raddr        read address
//   rdata        registered read data (one cycle latency)
// ---------------------------------------------------------------------------
module fb_mem
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = PIX_W,
    parameter int unsigned AW     = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array, deliberately without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fb_ctrl.sv
// ---------------------------------------------------------------------------
// fb_ctrl
// Framebuffer controller between a drawing client and the VGA timing
// generator. Serves generator reads with one cycle latency, accepts client
// writes via valid/ready, and contains a clear engine that fills the whole
// buffer with one colour.
//
// Optional feature macro: FB_TEAR_GUARD_EN
//   defined   - client writes and fill writes only while !visible; a fill
//               first waits for frame_end.
//   undefined - writes are never blanking-qualified; WAIT is unreachable.
//
// Ports:
//   clk          video clock (same as generator vclk)
//   srst         synchronous active-high reset
//   rd_addr      read pixel address (generator req_addr)
//   rd_pixel     read data, one cycle after rd_addr; 0 when out of range
//   visible      generator active-video flag
//   frame_end    generator end-of-frame pulse
//   wr_valid/wr_ready/wr_addr/wr_pixel   client write handshake
//   clear_req    start a fill (IDLE only)
//   clear_color  fill colour, latched with clear_req
//   clear_busy   high whenever the clear engine is not IDLE
//   fill_done    one-cycle pulse at the end of a fill
// ---------------------------------------------------------------------------
module fb_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned BUF_WIDTH  = 640,
    parameter int unsigned BUF_HEIGHT = 480,
    parameter int unsigned BIT_DEPTH  = PIX_W
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [BIT_DEPTH-1:0] rd_pixel,
    input  logic                 visible,
    input  logic                 frame_end,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [BIT_DEPTH-1:0] wr_pixel,
    input  logic                 clear_req,
    input  logic [BIT_DEPTH-1:0] clear_color,
    output logic                 clear_busy,
    output logic                 fill_done
);

    localparam int unsigned       DEPTH     = fb_depth(BUF_WIDTH, BUF_HEIGHT);
    localparam int unsigned       MEM_AW    = fb_addr_bits(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    fb_state_t              state_q;
    fb_state_t              state_d;
    logic [ADDR_W-1:0]      cnt_q;
    logic [BIT_DEPTH-1:0]   color_q;
    logic                   rd_in_range_q;
    logic [BIT_DEPTH-1:0]   mem_rdata;

    logic                   fill_en;
    logic                   idle_wr_ok;
    logic                   fill_we;
    logic                   wr_fire;
    logic                   mem_we;
    logic [MEM_AW-1:0]      mem_waddr;
    logic [BIT_DEPTH-1:0]   mem_wdata;

    // Blanking qualification for writes.
`ifdef FB_TEAR_GUARD_EN
    assign fill_en    = !visible;
    assign idle_wr_ok = !visible;
`else
    logic unused_visible;
    assign fill_en        = 1'b1;
    assign idle_wr_ok     = 1'b1;
    assign unused_visible = visible;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
`ifdef FB_TEAR_GUARD_EN
                    state_d = WAIT;
`else
                    state_d = FILL;
`endif
                end
            end
            WAIT: begin
                if (frame_end) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                // Terminal compare against a constant: the counter never wraps.
                if (fill_en && (cnt_q == LAST_ADDR)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs and fill write strobe.
    always_comb begin
        clear_busy = 1'b1;
        fill_done  = 1'b0;
        wr_ready   = 1'b0;
        fill_we    = 1'b0;
        case (state_q)
            IDLE: begin
                clear_busy = 1'b0;
                wr_ready   = idle_wr_ok;
            end
            // A reset on this edge must not commit the pending fill word.
            FILL:    fill_we   = fill_en && !srst;
            DONE:    fill_done = 1'b1;
            default: ;
        endcase
    end

    // Fill counter and latched colour.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q   <= '0;
            color_q <= '0;
        end else if ((state_q == IDLE) && clear_req) begin
            cnt_q   <= '0;
            color_q <= clear_color;
        end else if (fill_we) begin
            cnt_q <= cnt_q + ADDR_W'(1);
        end
    end

    // Out-of-range reads return zero; the flag tracks the registered read.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_in_range_q <= 1'b0;
        end else begin
            rd_in_range_q <= (rd_addr < DEPTH_A);
        end
    end

    assign rd_pixel = rd_in_range_q ? mem_rdata : '0;

    // Write port mux: the clear engine and the client never overlap since
    // wr_ready is only high in IDLE. Out-of-range client writes are dropped.
    assign wr_fire   = wr_valid && wr_ready && (wr_addr < DEPTH_A);
    assign mem_we    = fill_we || wr_fire;
    assign mem_waddr = fill_we ? MEM_AW'(cnt_q) : MEM_AW'(wr_addr);
    assign mem_wdata = fill_we ? color_q : wr_pixel;

    fb_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (BIT_DEPTH),
        .AW     (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (MEM_AW'(rd_addr)),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_fb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fb_ctrl
// Self-checking bench for fb_ctrl on a 4x2 buffer. Read expectations come
// from a local memory model and go through a queue; handshake and clear
// engine behaviour is checked with vector tables and short sequences.
// ---------------------------------------------------------------------------
module tb_fb_ctrl;

    localparam int unsigned W     = 4;
    localparam int unsigned H     = 2;
    localparam int unsigned DEPTH = W * H;
    localparam int unsigned BD    = 3;

    logic          clk = 1'b0;
    logic          srst;
    logic [19:0]   rd_addr;
    logic [BD-1:0] rd_pixel;
    logic          visible;
    logic          frame_end;
    logic          wr_valid;
    logic          wr_ready;
    logic [19:0]   wr_addr;
    logic [BD-1:0] wr_pixel;
    logic          clear_req;
    logic [BD-1:0] clear_color;
    logic          clear_busy;
    logic          fill_done;

    fb_ctrl #(
        .BUF_WIDTH  (W),
        .BUF_HEIGHT (H),
        .BIT_DEPTH  (BD)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .rd_addr     (rd_addr),
        .rd_pixel    (rd_pixel),
        .visible     (visible),
        .frame_end   (frame_end),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_pixel    (wr_pixel),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .fill_done   (fill_done)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [BD-1:0] model [DEPTH];
    logic [BD-1:0] exp_q [$];

    typedef struct {
        bit            wv;
        logic [19:0]   wa;
        logic [BD-1:0] wp;
        logic [19:0]   ra;
        bit            er;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One clock: optionally queue a read expectation, advance, update model.
    task automatic step(input bit chk_rd, input bit exp_acc, input string nm);
        logic [BD-1:0] e;
        bit            acc;
        if (chk_rd) begin
            e = (rd_addr < 20'(DEPTH)) ? model[rd_addr[2:0]] : '0;
            exp_q.push_back(e);
        end
        acc = wr_valid && exp_acc;
        @(posedge clk);
        #1;
        if (acc && (wr_addr < 20'(DEPTH))) model[wr_addr[2:0]] = wr_pixel;
        if (chk_rd) chk(nm, 32'(rd_pixel), 32'(exp_q.pop_front()));
    endtask

    task automatic read_all(input string nm);
        for (int a = 0; a < int'(DEPTH); a++) begin
            rd_addr = 20'(a);
            step(1'b1, 1'b0, $sformatf("%s_a%0d", nm, a));
        end
    endtask

    // Leaves the DUT just after the edge that enters FILL.
    task automatic start_fill(input logic [BD-1:0] c);
        clear_req   = 1'b1;
        clear_color = c;
        step(1'b0, 1'b0, "");
        clear_req = 1'b0;
`ifdef FB_TEAR_GUARD_EN
        step(1'b0, 1'b0, "");
        chk("wait_busy", 32'(clear_busy), 32'd1);
        frame_end = 1'b1;
        step(1'b0, 1'b0, "");
        frame_end = 1'b0;
`endif
    endtask

    task automatic wait_done(input string nm, input logic [BD-1:0] c);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            step(1'b0, 1'b0, "");
            if (fill_done) seen = 1'b1;
        end
        chk(nm, 32'(seen), 32'd1);
        step(1'b0, 1'b0, "");
        for (int a = 0; a < int'(DEPTH); a++) model[a] = c;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int busy_cnt;
        int done_cnt;
        int done_at;
        int rdy_bad;
        int n;

        // {wr_valid, wr_addr, wr_pixel, rd_addr, expected wr_ready}
        vecs[0] = '{1'b1, 20'd6,       3'b101, 20'd6,       1'b1};
        vecs[1] = '{1'b0, 20'd0,       3'b000, 20'd6,       1'b1};
        vecs[2] = '{1'b1, 20'd5,       3'b010, 20'd5,       1'b1};
        vecs[3] = '{1'b0, 20'd0,       3'b000, 20'd5,       1'b1};
        vecs[4] = '{1'b1, 20'd8,       3'b100, 20'd8,       1'b1};
        vecs[5] = '{1'b1, 20'd15,      3'b001, 20'd0,       1'b1};
        vecs[6] = '{1'b0, 20'd0,       3'b000, 20'd8,       1'b1};
        vecs[7] = '{1'b1, 20'd3,       3'b001, 20'd2,       1'b1};
        vecs[8] = '{1'b0, 20'd0,       3'b000, 20'd3,       1'b1};
        vecs[9] = '{1'b0, 20'd0,       3'b000, 20'hFFFFF,   1'b1};

        srst = 1'b1; rd_addr = '0; visible = 1'b0; frame_end = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_pixel = '0;
        clear_req = 1'b0; clear_color = '0;
        repeat (3) step(1'b0, 1'b0, "");
        chk("rst_rd_pixel",   32'(rd_pixel),   32'd0);
        chk("rst_clear_busy", 32'(clear_busy), 32'd0);
        chk("rst_fill_done",  32'(fill_done),  32'd0);
        chk("rst_wr_ready",   32'(wr_ready),   32'd1);
        srst = 1'b0;
`ifdef FB_TEAR_GUARD_EN
        visible = 1'b1;
        #1;
        chk("guard_ready_visible", 32'(wr_ready), 32'd0);
        visible = 1'b0;
`endif

        // Known contents: fill everything with 3'b111.
        start_fill(3'b111);
        wait_done("init_fill_done", 3'b111);

        // Table-driven writes and reads.
        for (int i = 0; i < 10; i++) begin
            wr_valid = vecs[i].wv;
            wr_addr  = vecs[i].wa;
            wr_pixel = vecs[i].wp;
            rd_addr  = vecs[i].ra;
            #1;
            chk($sformatf("vec%0d_wr_ready", i), 32'(wr_ready), 32'(vecs[i].er));
            step(1'b1, vecs[i].er, $sformatf("vec%0d_rd", i));
        end
        wr_valid = 1'b0;

`ifndef FB_TEAR_GUARD_EN
        // Fill with a client write on the same cycle as clear_req.
        clear_req = 1'b1; clear_color = 3'b011;
        wr_valid = 1'b1; wr_addr = 20'd4; wr_pixel = 3'b110;
        #1;
        chk("clr_with_wr_ready", 32'(wr_ready), 32'd1);
        step(1'b0, 1'b1, "");
        clear_req = 1'b0; wr_valid = 1'b0;
        cyc = 0; busy_cnt = 0; done_cnt = 0; done_at = 0; rdy_bad = 0;
        while (clear_busy && cyc < 40) begin
            cyc++;
            busy_cnt++;
            if (fill_done) begin done_cnt++; done_at = cyc; end
            if (wr_ready) rdy_bad++;
            // A request mid-fill must be ignored.
            clear_req   = (cyc == 3);
            clear_color = (cyc == 3) ? 3'b101 : 3'b011;
            step(1'b0, 1'b0, "");
        end
        clear_req = 1'b0;
        chk("fill_busy_cycles", 32'(busy_cnt), 32'd9);
        chk("fill_done_count",  32'(done_cnt), 32'd1);
        chk("fill_done_cycle",  32'(done_at),  32'd9);
        chk("fill_ready_low",   32'(rdy_bad),  32'd0);
        repeat (3) step(1'b0, 1'b0, "");
        chk("no_queued_fill", 32'(clear_busy), 32'd0);
        for (int a = 0; a < int'(DEPTH); a++) model[a] = 3'b011;
        read_all("fill011");
`endif

        // Reset with the counter at 3.
        start_fill(3'b110);
        repeat (3) step(1'b0, 1'b0, "");
        srst = 1'b1;
        step(1'b0, 1'b0, "");
        chk("abort_clear_busy", 32'(clear_busy), 32'd0);
        chk("abort_fill_done",  32'(fill_done),  32'd0);
        chk("abort_rd_pixel",   32'(rd_pixel),   32'd0);
        srst = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, "");
            if (fill_done) n++;
        end
        chk("abort_no_done_pulse", 32'(n), 32'd0);
        for (int a = 0; a < 3; a++) model[a] = 3'b110;
        read_all("abort");

`ifdef FB_TEAR_GUARD_EN
        // Fill held off while visible, then one word per blanking cycle.
        clear_req = 1'b1; clear_color = 3'b001;
        step(1'b0, 1'b0, "");
        clear_req = 1'b0;
        visible = 1'b1; frame_end = 1'b1;
        step(1'b0, 1'b0, "");
        frame_end = 1'b0;
        chk("guard_fill_busy", 32'(clear_busy), 32'd1);
        repeat (4) step(1'b0, 1'b0, "");
        rd_addr = 20'd0;
        step(1'b1, 1'b0, "guard_no_write_visible");
        visible = 1'b0;
        n = 0;
        while (!fill_done && n < 64) begin
            step(1'b0, 1'b0, "");
            n++;
        end
        chk("guard_fill_cycles", 32'(n), 32'd8);
        step(1'b0, 1'b0, "");
        for (int a = 0; a < int'(DEPTH); a++) model[a] = 3'b001;
        read_all("guard_fill");
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
